// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file write port between the ALU and
// load writeback paths. Memory has fixed priority. After STARVE_LIMIT
// consecutive contested memory wins, the ALU is forced to win the next grant.
// The winning write is registered, so wen/rd/din follow a transfer by one cycle.
// Writes to x0 complete their handshake but never assert wen.
// Optional macro WB_BYPASS_EN: adds byp_valid/byp_rd/byp_data, which mirror the
// in-flight write so decode can forward around the register file.
module regfile_wb_arbiter #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned RA_W         = 5,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hold,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [RA_W-1:0] alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic [RA_W-1:0] mem_rd,
  input  logic [XLEN-1:0] mem_data,
  output logic            wen,
  output logic [RA_W-1:0] rd,
  output logic [XLEN-1:0] din,
  output logic [3:0]      starve_cnt
`ifdef WB_BYPASS_EN
  ,
  output logic            byp_valid,
  output logic [RA_W-1:0] byp_rd,
  output logic [XLEN-1:0] byp_data
`endif
);

  typedef enum logic {PRI_MEM, PRI_ALU} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t          state, state_n;
  logic [3:0]      cnt_n;
  logic            xfer;
  logic [RA_W-1:0] xfer_rd;
  logic [XLEN-1:0] xfer_data;

  // Arbitration state register; frozen while hold is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= PRI_MEM;
      starve_cnt <= '0;
    end else begin
      state      <= state_n;
      starve_cnt <= cnt_n;
    end
  end

  // Grant selection and next-state logic.
  always_comb begin
    alu_ready = 1'b0;
    mem_ready = 1'b0;
    state_n   = state;
    cnt_n     = starve_cnt;
    if (!rst && !hold) begin
      unique case (state)
        PRI_MEM: begin
          if (mem_valid && alu_valid) begin
            mem_ready = 1'b1;
            if (starve_cnt + 4'd1 == LIMIT) begin
              state_n = PRI_ALU;
              cnt_n   = '0;
            end else begin
              cnt_n = starve_cnt + 4'd1;
            end
          end else if (mem_valid) begin
            mem_ready = 1'b1;
          end else if (alu_valid) begin
            alu_ready = 1'b1;
            cnt_n     = '0;
          end
        end
        PRI_ALU: begin
          if (alu_valid) begin
            alu_ready = 1'b1;
            state_n   = PRI_MEM;
            cnt_n     = '0;
          end else if (mem_valid) begin
            mem_ready = 1'b1;
          end
        end
        default: begin
          state_n = PRI_MEM;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // Mux the winning request's payload.
  always_comb begin
    xfer      = alu_ready || mem_ready;
    xfer_rd   = mem_ready ? mem_rd   : alu_rd;
    xfer_data = mem_ready ? mem_data : alu_data;
  end

  // Output register: one write per transfer, x0 suppressed, rd/din held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      wen <= 1'b0;
      rd  <= '0;
      din <= '0;
    end else begin
      wen <= xfer && (xfer_rd != '0);
      if (xfer) begin
        rd  <= xfer_rd;
        din <= xfer_data;
      end
    end
  end

`ifdef WB_BYPASS_EN
  // Forwarding view of the write currently presented to the register file.
  always_comb begin
    byp_valid = wen && (rd != '0);
    byp_rd    = rd;
    byp_data  = din;
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter (default parameters, STARVE_LIMIT=3).
// The driver applies hand-computed vectors and checks the grants. It pushes each
// expected register write, together with the cycle it must appear in, onto a
// queue. A negedge monitor pops that queue whenever wen is seen.
module tb_regfile_wb_arbiter;

  localparam int XLEN = 32;
  localparam int RA_W = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            hold = 1'b0;
  logic            alu_valid = 1'b0, mem_valid = 1'b0;
  logic            alu_ready, mem_ready;
  logic [RA_W-1:0] alu_rd = '0, mem_rd = '0;
  logic [XLEN-1:0] alu_data = '0, mem_data = '0;
  logic            wen;
  logic [RA_W-1:0] rd;
  logic [XLEN-1:0] din;
  logic [3:0]      starve_cnt;
`ifdef WB_BYPASS_EN
  logic            byp_valid;
  logic [RA_W-1:0] byp_rd;
  logic [XLEN-1:0] byp_data;
`endif

  regfile_wb_arbiter #(.XLEN(XLEN), .RA_W(RA_W), .STARVE_LIMIT(3)) dut (
    .clk(clk), .rst(rst), .hold(hold),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .wen(wen), .rd(rd), .din(din), .starve_cnt(starve_cnt)
`ifdef WB_BYPASS_EN
    , .byp_valid(byp_valid), .byp_rd(byp_rd), .byp_data(byp_data)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int              cyc;
    logic [RA_W-1:0] rd;
    logic [XLEN-1:0] data;
  } wr_t;

  wr_t             exp_q[$];
  int              cyc = 0;
  int              nvec = 0;
  int              nerr = 0;
  logic [XLEN-1:0] rf_obs [32];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every wen must match the oldest expected write, in the expected cycle.
  always @(negedge clk) begin
    wr_t e;
    if (wen) begin
      nvec++;
      if (exp_q.size() == 0) begin
        nerr++;
        $display("FAIL unexpected_write: got rd=%0d din=0x%0h expected no write (cycle %0d)", rd, din, cyc);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.rd != rd || e.data != din) begin
          nerr++;
          $display("FAIL write: got cyc=%0d rd=%0d din=0x%0h expected cyc=%0d rd=%0d din=0x%0h",
                   cyc, rd, din, e.cyc, e.rd, e.data);
        end
        rf_obs[rd] = din;
      end
    end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      nvec++;
      nerr++;
      $display("FAIL missing_write: got wen=0 expected rd=%0d din=0x%0h (cycle %0d)", e.rd, e.data, cyc);
    end
`ifdef WB_BYPASS_EN
    chk("byp_valid", 32'(byp_valid), 32'(wen && rd != '0));
    if (wen) begin
      chk("byp_rd", 32'(byp_rd), 32'(rd));
      chk("byp_data", byp_data, din);
    end
`endif
  end

  // Apply one vector for one cycle: check the grants, queue the expected write,
  // then check starve_cnt after the edge.
  task automatic step(input logic av, input logic [RA_W-1:0] ar, input logic [XLEN-1:0] ad,
                      input logic mv, input logic [RA_W-1:0] mr, input logic [XLEN-1:0] md,
                      input logic h, input logic exp_ar, input logic exp_mr,
                      input logic [3:0] exp_cnt, input string nm);
    wr_t w;
    alu_valid = av; alu_rd = ar; alu_data = ad;
    mem_valid = mv; mem_rd = mr; mem_data = md;
    hold = h;
    #1;
    chk({nm, ".alu_ready"}, 32'(alu_ready), 32'(exp_ar));
    chk({nm, ".mem_ready"}, 32'(mem_ready), 32'(exp_mr));
    w.cyc = cyc + 1;
    if (exp_mr && mr != '0) begin w.rd = mr; w.data = md; exp_q.push_back(w); end
    if (exp_ar && ar != '0) begin w.rd = ar; w.data = ad; exp_q.push_back(w); end
    @(posedge clk); #1;
    chk({nm, ".starve_cnt"}, 32'(starve_cnt), 32'(exp_cnt));
  endtask

  initial begin
    // Reset with both requesters asserting.
    #1;
    alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h22;
    mem_valid = 1'b1; mem_rd = 5'd1; mem_data = 32'h11;
    repeat (2) begin
      #1;
      chk("rst.alu_ready", 32'(alu_ready), 32'd0);
      chk("rst.mem_ready", 32'(mem_ready), 32'd0);
      @(posedge clk); #1;
      chk("rst.wen", 32'(wen), 32'd0);
      chk("rst.rd", 32'(rd), 32'd0);
      chk("rst.din", din, 32'd0);
      chk("rst.starve_cnt", 32'(starve_cnt), 32'd0);
    end
    rst = 1'b0;

    // av  ar     ad            mv  mr     md        h  ear emr cnt
    step(1, 5'd2, 32'h22,       1, 5'd1, 32'h11,    0, 0, 1, 4'd1, "release");
    step(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0,     0, 1, 0, 4'd0, "alu_single");
    step(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,     0, 0, 0, 4'd0, "idle0");
    step(0, 5'd0, 32'h0,        1, 5'd0, 32'h1234,  0, 0, 1, 4'd0, "x0_drop");
    step(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,     0, 0, 0, 4'd0, "idle1");

    // Starvation: mem, mem, mem, alu, mem, mem, mem, alu.
    step(1, 5'd20, 32'hA1, 1, 5'd8,  32'h100, 0, 0, 1, 4'd1, "starve1");
    step(1, 5'd20, 32'hA1, 1, 5'd9,  32'h101, 0, 0, 1, 4'd2, "starve2");
    step(1, 5'd20, 32'hA1, 1, 5'd10, 32'h102, 0, 0, 1, 4'd0, "starve3");
    step(1, 5'd20, 32'hA1, 1, 5'd11, 32'h103, 0, 1, 0, 4'd0, "starve4");
    step(1, 5'd21, 32'hA2, 1, 5'd11, 32'h103, 0, 0, 1, 4'd1, "starve5");
    step(1, 5'd21, 32'hA2, 1, 5'd12, 32'h104, 0, 0, 1, 4'd2, "starve6");
    step(1, 5'd21, 32'hA2, 1, 5'd13, 32'h105, 0, 0, 1, 4'd0, "starve7");
    step(1, 5'd21, 32'hA2, 1, 5'd14, 32'h106, 0, 1, 0, 4'd0, "starve8");

    // Hold mid-stream: the write accepted just before hold still issues.
    step(1, 5'd22, 32'hA3, 1, 5'd14, 32'h106, 0, 0, 1, 4'd1, "pre_hold");
    for (int i = 0; i < 4; i++)
      step(1, 5'd22, 32'hA3, 1, 5'd15, 32'h107, 1, 0, 0, 4'd1, "hold");
    step(1, 5'd22, 32'hA3, 1, 5'd15, 32'h107, 0, 0, 1, 4'd2, "post_hold1");
    step(1, 5'd22, 32'hA3, 1, 5'd16, 32'h108, 0, 0, 1, 4'd0, "post_hold2");
    step(1, 5'd22, 32'hA3, 1, 5'd17, 32'h109, 0, 1, 0, 4'd0, "post_hold3");

    // PRI_ALU with only mem requesting: mem granted, ALU priority kept.
    step(1, 5'd23, 32'hA4, 1, 5'd17, 32'h109, 0, 0, 1, 4'd1, "pa1");
    step(1, 5'd23, 32'hA4, 1, 5'd18, 32'h10A, 0, 0, 1, 4'd2, "pa2");
    step(1, 5'd23, 32'hA4, 1, 5'd19, 32'h10B, 0, 0, 1, 4'd0, "pa3");
    step(0, 5'd23, 32'hA4, 1, 5'd24, 32'h10C, 0, 0, 1, 4'd0, "pa_mem_only");
    step(1, 5'd23, 32'hA4, 1, 5'd25, 32'h10D, 0, 1, 0, 4'd0, "pa_alu");

    // Same destination: later grant wins.
    step(0, 5'd0, 32'h0, 1, 5'd7, 32'hA, 0, 0, 1, 4'd0, "same_mem");
    step(1, 5'd7, 32'hB, 0, 5'd0, 32'h0, 0, 1, 0, 4'd0, "same_alu");
    step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0, 4'd0, "drain0");
    step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0, 4'd0, "drain1");
    @(negedge clk);
    chk("rf_x7", rf_obs[7], 32'hB);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
